// File: rtl/keystream_serialiser_if.sv
// Block-in / byte-out bundle for the keystream serialiser; slave modport is the serialiser side.
interface keystream_serialiser_if #(
    parameter int DATA_SIZE = 8,
    parameter int NUM_WORDS = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_block [0:NUM_WORDS-1];
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_SIZE-1:0] out_data;
    logic                 out_block_end;
    logic                 out_msg_end;
    logic [1:0]           occupancy;

    modport master (
        output in_valid, in_block, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_block_end, out_msg_end, occupancy
    );

    modport slave (
        input  in_valid, in_block, in_last, out_ready,
        output in_ready, out_valid, out_data, out_block_end, out_msg_end, occupancy
    );
endinterface

// File: rtl/keystream_serialiser.sv
// Two-slot ping-pong buffer turning 512-bit keystream blocks into an LE byte stream, 1 byte/cycle.
// Byte 0 is visible the cycle after accept; in_ready depends only on occupancy, so a full buffer stalls input one extra cycle.
module keystream_serialiser #(
    parameter int DATA_SIZE = 8,
    parameter int NUM_WORDS = 16,
    parameter int NUM_BYTES = NUM_WORDS * 4,
    parameter int NUM_SLOTS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    keystream_serialiser_if.slave bus
);
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [5:0] LAST_BYTE = 6'(NUM_BYTES - 1);

    state_t               state;
    word_t                slot_words [NUM_SLOTS][NUM_WORDS];
    logic [NUM_SLOTS-1:0] slot_last;
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [5:0]           byte_idx;

    logic  accept;
    logic  xfer;
    logic  final_pop;
    word_t cur_word;

    // rst gates in_ready directly so nothing is accepted while reset is held.
    assign bus.in_ready  = !rst && (state != TWO);
    assign bus.out_valid = (state != EMPTY);
    assign bus.occupancy = state;

    assign accept    = bus.in_valid && bus.in_ready;
    assign xfer      = bus.out_valid && bus.out_ready;
    assign final_pop = xfer && (byte_idx == LAST_BYTE);

    assign cur_word          = slot_words[rd_ptr][byte_idx[5:2]];
    assign bus.out_data      = cur_word[{byte_idx[1:0], 3'b000} +: DATA_SIZE];
    assign bus.out_block_end = bus.out_valid && (byte_idx == LAST_BYTE);
    assign bus.out_msg_end   = bus.out_block_end && slot_last[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            byte_idx  <= 6'd0;
            slot_last <= '0;
            for (int s = 0; s < NUM_SLOTS; s++) begin
                for (int w = 0; w < NUM_WORDS; w++) begin
                    slot_words[s][w] <= '0;
                end
            end
        end else begin
            if (accept) begin
                for (int w = 0; w < NUM_WORDS; w++) begin
                    slot_words[wr_ptr][w] <= bus.in_block[w];
                end
                slot_last[wr_ptr] <= bus.in_last;
                wr_ptr            <= ~wr_ptr;
            end

            // 6-bit counter wraps to 0 naturally after byte 63.
            if (xfer) begin
                byte_idx <= byte_idx + 6'd1;
                if (final_pop) begin
                    rd_ptr <= ~rd_ptr;
                end
            end

            case (state)
                EMPTY: if (accept) state <= ONE;
                ONE: begin
                    if (accept && !final_pop) begin
                        state <= TWO;
                    end else if (!accept && final_pop) begin
                        state <= EMPTY;
                    end
                end
                TWO:     if (final_pop) state <= ONE;
                default: state <= EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_keystream_serialiser.sv
// Directed bench for keystream_serialiser: ramp, stall, ping-pong, backpressure, in_last tagging, async reset.
module tb_keystream_serialiser;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    keystream_serialiser_if bus();

    keystream_serialiser dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // kind 0: word w = {4w+3,4w+2,4w+1,4w}; kind 1: 0xAAAAAAAA; otherwise 0x55555555
    task automatic set_block(input int kind);
        for (int w = 0; w < 16; w++) begin
            case (kind)
                0:       bus.in_block[w] = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
                1:       bus.in_block[w] = 32'hAAAA_AAAA;
                default: bus.in_block[w] = 32'h5555_5555;
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic single_ramp(input string tag);
        set_block(0);
        bus.in_last   = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        check({tag, "_occ_start"}, 32'(bus.occupancy), 32'd1);
        for (int k = 0; k < 64; k++) begin
            check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, "_data"}, 32'(bus.out_data), 32'(k));
            check({tag, "_blk_end"}, 32'(bus.out_block_end), 32'(k == 63));
            check({tag, "_msg_end"}, 32'(bus.out_msg_end), 32'd0);
            step();
        end
        check({tag, "_valid_end"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_occ_end"}, 32'(bus.occupancy), 32'd0);
    endtask

    initial begin
        logic [7:0] exp_b;

        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        set_block(0);

        // reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_occ", 32'(bus.occupancy), 32'd0);
        check("rst_data", 32'(bus.out_data), 32'd0);
        check("rst_blk_end", 32'(bus.out_block_end), 32'd0);
        check("rst_msg_end", 32'(bus.out_msg_end), 32'd0);
        rst = 1'b0;
        #1;
        check("rel_in_ready", 32'(bus.in_ready), 32'd1);

        // single ramp block under continuous out_ready
        single_ramp("ramp");

        // same block with out_ready 0,1,0,1...: each byte seen twice
        set_block(0);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        step();
        bus.in_valid = 1'b0;
        for (int c = 0; c < 128; c++) begin
            check("tog_valid", 32'(bus.out_valid), 32'd1);
            check("tog_data", 32'(bus.out_data), 32'(c / 2));
            check("tog_blk_end", 32'(bus.out_block_end), 32'((c / 2) == 63));
            bus.out_ready = (c % 2 == 1);
            step();
        end
        check("tog_valid_end", 32'(bus.out_valid), 32'd0);
        check("tog_occ_end", 32'(bus.occupancy), 32'd0);

        // A (0xAA), B (0x55, in_last), then C (ramp) offered while full
        bus.out_ready = 1'b1;
        set_block(1);
        bus.in_last  = 1'b0;
        bus.in_valid = 1'b1;
        step();
        for (int i = 0; i < 192; i++) begin
            if (i < 64)       exp_b = 8'hAA;
            else if (i < 128) exp_b = 8'h55;
            else              exp_b = 8'(i - 128);
            check("pp_valid", 32'(bus.out_valid), 32'd1);
            check("pp_data", 32'(bus.out_data), 32'(exp_b));
            check("pp_blk_end", 32'(bus.out_block_end), 32'(i % 64 == 63));
            check("pp_msg_end", 32'(bus.out_msg_end), 32'(i == 127));
            if (i == 0) begin
                check("pp_occ", 32'(bus.occupancy), 32'd1);
                check("pp_in_ready", 32'(bus.in_ready), 32'd1);
            end else if (i < 64) begin
                check("pp_occ", 32'(bus.occupancy), 32'd2);
                check("pp_in_ready", 32'(bus.in_ready), 32'd0);
            end else if (i == 64) begin
                check("pp_occ", 32'(bus.occupancy), 32'd1);
                check("pp_in_ready", 32'(bus.in_ready), 32'd1);
            end else if (i < 128) begin
                check("pp_occ", 32'(bus.occupancy), 32'd2);
                check("pp_in_ready", 32'(bus.in_ready), 32'd0);
            end else begin
                check("pp_occ", 32'(bus.occupancy), 32'd1);
                check("pp_in_ready", 32'(bus.in_ready), 32'd1);
            end
            if (i == 0) begin
                set_block(2);
                bus.in_last = 1'b1;
            end else if (i == 1) begin
                set_block(0);
                bus.in_last = 1'b0;
            end else if (i == 65) begin
                bus.in_valid = 1'b0;
            end
            step();
        end
        check("pp_valid_end", 32'(bus.out_valid), 32'd0);
        check("pp_occ_end", 32'(bus.occupancy), 32'd0);

        // asynchronous reset after 20 bytes
        set_block(0);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (20) step();
        check("ar_data_pre", 32'(bus.out_data), 32'd20);
        #2;
        rst = 1'b1;
        #1;
        check("ar_valid", 32'(bus.out_valid), 32'd0);
        check("ar_occ", 32'(bus.occupancy), 32'd0);
        check("ar_data", 32'(bus.out_data), 32'd0);
        check("ar_in_ready", 32'(bus.in_ready), 32'd0);
        check("ar_blk_end", 32'(bus.out_block_end), 32'd0);
        step();
        rst = 1'b0;
        single_ramp("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/keystream_serialiser.md
Name: keystream_serialiser

Overview:
- Takes complete 512-bit ChaCha20 keystream blocks (16 x 32-bit state words) from the block core.
- Emits them as a byte stream, one byte per cycle, in RFC 8439 little-endian serialisation order.
- Sits directly upstream of the byte concatenator and feeds its 8-bit input_data_split port.
- Holds two blocks in a ping-pong buffer, so the core can deliver the next block while the current one drains.

Parameters:
- DATA_SIZE, 8, output byte width; only 8 is supported.
- NUM_WORDS, 16, 32-bit words per block.
- NUM_BYTES, NUM_WORDS*4 (64), bytes emitted per block.
- NUM_SLOTS, 2, block buffer depth; only 2 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_block and in_last are valid.
- in_ready  out  1  serialiser can accept a block this cycle.
- in_block  in  32 x NUM_WORDS  unpacked word_t array [0:15]; word 0 is state word 0.
- in_last  in  1  this block is the final block of the message.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the byte this cycle.
- out_data  out  DATA_SIZE  serialised byte.
- out_block_end  out  1  out_data is byte 63 of its block.
- out_msg_end  out  1  out_block_end of a block that was tagged in_last.
- occupancy  out  2  blocks currently held (0..2).

Behaviour:
- Reset (async assert, sync deassert): slots cleared, both pointers 0, byte_idx=0, occupancy=0, out_valid=0, out_data=0, out_block_end=0, out_msg_end=0. in_ready=0 while rst is high, then 1.
- Input handshake:
  - Block accepted on a rising edge with in_valid && in_ready.
  - Block and in_last are stored into slot wr_ptr; wr_ptr toggles.
  - in_ready = (occupancy < 2), registered-state only. There is no combinational path from out_ready or out_valid to in_ready.
  - When occupancy==2, in_ready=0 even if the final byte pops in the same cycle. This costs one bubble cycle on the input side only.
- Output handshake:
  - A byte transfers on a rising edge with out_valid && out_ready.
  - out_valid = (occupancy > 0).
  - out_data, out_block_end and out_msg_end are combinational selects from registered state (slot rd_ptr, byte_idx). No extra pipeline register.
  - Outputs must stay stable while out_valid && !out_ready.
- Byte order: byte_idx k selects word k>>2, bits [8*(k&3)+7 : 8*(k&3)]. Word 0 bits [7:0] go first; word 15 bits [31:24] go last.
- Counter: byte_idx is a 6-bit counter that increments on each transfer. On the transfer of byte 63 it wraps to 0 and rd_ptr toggles.
- Occupancy update: +1 on accept, -1 on transfer of byte 63, unchanged when both happen in the same cycle.
- State machine, occupancy-encoded:
  - EMPTY (0) -> ONE on accept.
  - ONE (1) -> TWO on accept without final pop.
  - ONE (1) -> EMPTY on final pop without accept.
  - ONE (1) -> ONE when accept and final pop coincide.
  - TWO (2) -> ONE on final pop.
- Latency: a block accepted at edge N into an empty buffer presents byte 0 from edge N onward, with out_valid high in cycle N+1.
- Throughput: 64 bytes per 64 cycles under continuous out_ready, with no bubble between back-to-back buffered blocks.
- Tags:
  - out_block_end is high only when byte_idx==63 and out_valid.
  - out_msg_end is high only when out_block_end is high and the slot's stored in_last is 1.
- Illegal inputs: in_valid while in_ready=0 is ignored and has no side effect. in_block is sampled only at accept.
- Reset mid-operation: all buffered data is discarded and outputs return to reset values immediately. There is no partial-block flush.

Test Plan:
- Single block, in_block[w] = {4w+3, 4w+2, 4w+1, 4w} bytes, out_ready=1 -> out_data = 0x00, 0x01 … 0x3F on 64 consecutive cycles; out_block_end only on 0x3F; occupancy 1 -> 0.
- Same block, out_ready toggling 1,0,1,0 -> each byte held stable during low cycles; 64 transfers in 128 cycles; order unchanged.
- Two blocks (A: all words 0xAAAAAAAA, B: 0x55555555) offered back-to-back -> both accepted, occupancy 2, in_ready=0; 64 x 0xAA immediately followed by 64 x 0x55 with no bubble.
- Third block offered while occupancy==2 -> in_ready low until the edge after A's byte 63 pops; block C is then accepted and streams after B.
- in_last=1 on the second of two blocks -> out_msg_end pulses exactly once, on the 128th byte; out_block_end pulses on the 64th and 128th bytes.
- rst asserted asynchronously after 20 bytes of a block -> out_valid drops without waiting for a clock edge, occupancy=0; after release a new block streams from byte 0x00.
